// File: rtl/banco_registradores_pkg.sv
// Shared MIPS register-file constants, also used by control and the RegDst/jal muxes.
package banco_registradores_pkg;
   localparam int          LARGURA_REG = 32;
   localparam int          NUM_REGS    = 32;
   localparam int          END_W       = 5;
   localparam logic [4:0]  REG_ZERO    = 5'd0;
   localparam logic [4:0]  REG_SP      = 5'd29;
   localparam logic [4:0]  REG_RA      = 5'd31;
   localparam logic [31:0] SP_INIT     = 32'h0000_03FC;

   // True when the address names a real, writable register (not $zero, not past the array)
   function automatic logic end_valido(input logic [END_W-1:0] endereco, input int num_regs);
      return (endereco != REG_ZERO) && (int'(endereco) < num_regs);
   endfunction
endpackage

// File: rtl/banco_registradores_porta_leitura.sv
// One combinational read port: forces $zero, forwards the in-flight write when enabled,
// otherwise selects the stored register.
module banco_registradores_porta_leitura
   import banco_registradores_pkg::*;
#(
   parameter int LARGURA  = 32,
   parameter int NUM_REGS = 32,
   parameter bit BYPASS   = 1'b1
) (
   input  logic [NUM_REGS-1:0][LARGURA-1:0] banco,
   input  logic [END_W-1:0]                 endereco,
   input  logic                             reg_write,
   input  logic                             reset,
   input  logic [END_W-1:0]                 end_esc,
   input  logic [LARGURA-1:0]               dado_esc,
   output logic [LARGURA-1:0]               dado
);
   always_comb begin
      dado = '0;
      if (!end_valido(endereco, NUM_REGS))
         dado = '0;
      else if (BYPASS && reg_write && !reset && (endereco == end_esc))
         dado = dado_esc;
      else
         dado = banco[endereco];
   end
endmodule

// File: rtl/banco_registradores.sv
// MIPS general-purpose register file: 2 combinational read ports, 1 synchronous write port,
// 1 non-bypassed debug port; $zero hardwired, $sp resets to SP_INIT.
module banco_registradores
   import banco_registradores_pkg::END_W;
   import banco_registradores_pkg::REG_SP;
   import banco_registradores_pkg::end_valido;
#(
   parameter int                LARGURA  = banco_registradores_pkg::LARGURA_REG,
   parameter int                NUM_REGS = banco_registradores_pkg::NUM_REGS,
   parameter bit                BYPASS   = 1'b1,
   parameter logic [LARGURA-1:0] SP_INIT = banco_registradores_pkg::SP_INIT
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               RegWrite,
   input  logic [END_W-1:0]   EndEscRD,
   input  logic [LARGURA-1:0] DadoEsc,
   input  logic [END_W-1:0]   EndRS,
   input  logic [END_W-1:0]   EndRT,
   output logic [LARGURA-1:0] DadoLido1,
   output logic [LARGURA-1:0] DadoLido2,
   input  logic [END_W-1:0]   EndDebug,
   output logic [LARGURA-1:0] DadoDebug
);
   logic [LARGURA-1:0]               regs [1:NUM_REGS-1];
   logic [NUM_REGS-1:0][LARGURA-1:0] banco;

   // Reset wins over a same-cycle write; writes to r0 or out of range are dropped
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 1; i < NUM_REGS; i++)
            regs[i] <= (i == int'(REG_SP)) ? SP_INIT : '0;
      end else if (RegWrite && end_valido(EndEscRD, NUM_REGS)) begin
         regs[EndEscRD] <= DadoEsc;
      end
   end

   always_comb begin
      banco = '0;
      for (int i = 1; i < NUM_REGS; i++)
         banco[i] = regs[i];
   end

   banco_registradores_porta_leitura #(
      .LARGURA(LARGURA), .NUM_REGS(NUM_REGS), .BYPASS(BYPASS)
   ) u_porta_rs (
      .banco(banco), .endereco(EndRS), .reg_write(RegWrite), .reset(reset),
      .end_esc(EndEscRD), .dado_esc(DadoEsc), .dado(DadoLido1)
   );

   banco_registradores_porta_leitura #(
      .LARGURA(LARGURA), .NUM_REGS(NUM_REGS), .BYPASS(BYPASS)
   ) u_porta_rt (
      .banco(banco), .endereco(EndRT), .reg_write(RegWrite), .reset(reset),
      .end_esc(EndEscRD), .dado_esc(DadoEsc), .dado(DadoLido2)
   );

   assign DadoDebug = end_valido(EndDebug, NUM_REGS) ? banco[EndDebug] : '0;
endmodule
